// File: rtl/debounce_sync.sv
// Input conditioner: N-flop synchronizer followed by a level qualifier that only
// updates out after the synchronized level has differed for STABLE_CYCLES cycles.
module debounce_sync #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter logic        RST_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic out,
  output logic busy,
  output logic glitch
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam bit SINGLE_CYCLE = (STABLE_CYCLES == 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("debounce_sync: SYNC_STAGES must be >= 2");
  end
  if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
    $error("debounce_sync: STABLE_CYCLES must be >= 1");
  end

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   out_d, busy_d, glitch_d;

  // Plain shift chain; flops reset to RST_VAL so reset release never looks like a change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // Qualifier state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      out     <= RST_VAL;
      busy    <= 1'b0;
      glitch  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out     <= out_d;
      busy    <= busy_d;
      glitch  <= glitch_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    out_d    = out;
    glitch_d = 1'b0;

    case (state_q)
      ST_STABLE: begin
        if (sync != out) begin
          if (SINGLE_CYCLE) begin
            out_d = sync;
          end else begin
            state_d = ST_PENDING;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ST_PENDING: begin
        if (sync == out) begin
          // Bounced back before qualifying: abandon and flag it.
          state_d  = ST_STABLE;
          cnt_d    = '0;
          glitch_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
          out_d   = sync;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d == ST_PENDING);
  end

endmodule
